mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers.
- Sits in the execute stage beside the combinational ALU and shares the same A/B operand buses.
- Executes MULT/MULTU/DIV/DIVU with fixed, ALU-independent latency and handles MTHI/MTLO writes.
- Exposes HI/LO and busy so the hazard unit can stall MFHI/MFLO and further MD ops.

Parameters:
- MULT_CYCLES, 5, busy cycles for multiply (and MADD/MADDU); legal range 1..15.
- DIV_CYCLES, 10, busy cycles for divide; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  qualifies MDop this cycle; MDop is ignored when 0.
- MDop  in  4  0000 none, 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU, 0101 MTHI, 0110 MTLO, 0111 MADD, 1000 MADDU.
- A  in  32  rs operand (dividend / multiplicand / MT source).
- B  in  32  rt operand (divisor / multiplier).
- HI  out  32  HI register.
- LO  out  32  LO register.
- busy  out  1  registered; high while an MD op is in flight.

Behaviour:
- Reset (rst_n=0, async): HI=0, LO=0, busy=0, counter=0, pending result=0. Reset mid-operation aborts the op; no HI/LO write occurs.
- States:
  - IDLE (busy=0).
  - RUN (busy=1, counter counts down).
- IDLE transitions:
  - start=1 with an arithmetic op in cycle k: capture pending {hi,lo} computed from A/B at that edge. Load counter with MULT_CYCLES or DIV_CYCLES. Go to RUN.
  - busy=1 for cycles k+1..k+N. At the edge ending cycle k+N, HI/LO are written, busy drops, return to IDLE. The new HI/LO are visible in cycle k+N+1.
- Arithmetic:
  - MULT: {HI,LO} = signed 32x32 -> 64.
  - MULTU: {HI,LO} = unsigned 32x32 -> 64.
  - DIV: LO = quotient truncated toward zero; HI = remainder, sign follows dividend.
  - DIVU: unsigned quotient/remainder.
- Divide by zero (B=0): the op still runs DIV_CYCLES with busy high; HI/LO are left unchanged at completion.
- Signed overflow 0x80000000 / -1 → LO=0x80000000, HI=0.
- MTHI/MTLO with start=1 in IDLE: HI (or LO) = A at that edge, single cycle, busy stays 0. The other register is unchanged.
- start=1 while busy=1: ignored entirely (any op, including MT). The pipeline guarantees a stall, but the unit must not corrupt state.
- start=1 with MDop=0000 or an undefined code: no-op.
- start=1 in the completion cycle (busy=1, counter at last count): ignored. A new op is accepted only when busy=0.
- HI/LO hold their values across IDLE indefinitely.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - MADD: {HI,LO} = {HI,LO} + signed(A)*signed(B), modulo 2^64.
  - MADDU: same accumulate, unsigned product.
  - Both use MULT_CYCLES. The accumulate base is {HI,LO} at the capture edge.
- Undefined: MDop 0111/1000 are treated as no-ops (no busy, no write).

Decomposition:
- Shared package mdu_pkg holds:
  - MDop encodings as localparams/typedef enum (MD_NONE, MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MADD, MD_MADDU).
  - Default cycle constants.
- The decoder in the controller imports the same package.
- One natural sub-module, mdu_arith: purely combinational, computes the 64-bit pending result from op/A/B/HI/LO.
- mdu_hilo keeps the counter, FSM and HI/LO registers.

Test Plan:
- Reset then idle: HI=LO=0, busy=0. Assert rst_n=0 mid-MULT in cycle 3 → busy=0, HI=LO=0, no later write.
- MULT A=0xFFFFFFFE (-2), B=3 → busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands → HI=0x00000002, LO=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 → busy 10 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=0 → 10 busy cycles, HI/LO unchanged.
- MTHI A=0x12345678 then MTLO A=0x9ABCDEF0 on consecutive cycles → HI/LO updated next cycle each, busy never asserted.
- During a DIV, pulse start with MTHI A=0xDEADBEEF and MULT → both ignored; final HI/LO equal the DIV result only.
- With MDU_MADD_EN: preload HI=0, LO=0xFFFFFFFF, MADDU A=1, B=1 → HI=1, LO=0 after 5 cycles. Without the macro, the same stimulus leaves HI/LO unchanged with busy=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   - MDop encodings (md_op_e), default cycle counts, HI/LO payload struct,
//     and a small decode helper used by the controller.
package mdu_pkg;

   localparam int unsigned XLEN            = 32;
   localparam int unsigned CNT_W           = 4;
   localparam int unsigned MULT_CYCLES_DEF = 5;
   localparam int unsigned DIV_CYCLES_DEF  = 10;

   typedef enum logic [3:0] {
      MD_NONE  = 4'h0,
      MD_MULT  = 4'h1,
      MD_MULTU = 4'h2,
      MD_DIV   = 4'h3,
      MD_DIVU  = 4'h4,
      MD_MTHI  = 4'h5,
      MD_MTLO  = 4'h6,
      MD_MADD  = 4'h7,
      MD_MADDU = 4'h8
   } md_op_e;

   // 64-bit {HI,LO} pair carried between the arithmetic block and registers
   typedef struct packed {
      logic [XLEN-1:0] hi;
      logic [XLEN-1:0] lo;
   } hilo_t;

   function automatic logic is_div(md_op_e op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational result generator for the multiply/divide unit.
//   op_i     : operation code
//   a_i, b_i : rs / rt operands
//   hilo_i   : current {HI,LO}, accumulate base for MADD/MADDU
//   res_c_o  : pending {HI,LO} result
//   wr_c_o   : result should be committed (low for divide by zero / non-arith)
module mdu_arith
   import mdu_pkg::*;
(
   input  md_op_e          op_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   input  hilo_t           hilo_i,
   output hilo_t           res_c_o,
   output logic            wr_c_o
);

   logic [2*XLEN-1:0] prod_s;
   logic [2*XLEN-1:0] prod_u;
   logic              div_sgn;
   logic              neg_a;
   logic              neg_b;
   logic [XLEN-1:0]   div_a;
   logic [XLEN-1:0]   div_b;
   logic [XLEN-1:0]   q_mag;
   logic [XLEN-1:0]   r_mag;
   logic [XLEN-1:0]   q_res;
   logic [XLEN-1:0]   r_res;

   // Products: signed via sign-extension to 64 bits, unsigned via zero-extension
   always_comb begin
      prod_s = $signed({{XLEN{a_i[XLEN-1]}}, a_i}) * $signed({{XLEN{b_i[XLEN-1]}}, b_i});
      prod_u = {{XLEN{1'b0}}, a_i} * {{XLEN{1'b0}}, b_i};
   end

   // Signed divide runs on magnitudes; quotient sign is the XOR of operand
   // signs, remainder takes the dividend sign. 0x80000000 / -1 falls out as
   // quotient 0x80000000, remainder 0 without special casing.
   always_comb begin
      div_sgn = (op_i == MD_DIV);
      neg_a   = div_sgn & a_i[XLEN-1];
      neg_b   = div_sgn & b_i[XLEN-1];
      div_a   = neg_a ? (~a_i + XLEN'(1)) : a_i;
      div_b   = neg_b ? (~b_i + XLEN'(1)) : b_i;
      q_mag   = '0;
      r_mag   = '0;
      if (div_b != '0) begin
         q_mag = div_a / div_b;
         r_mag = div_a % div_b;
      end
      q_res = (neg_a ^ neg_b) ? (~q_mag + XLEN'(1)) : q_mag;
      r_res = neg_a ? (~r_mag + XLEN'(1)) : r_mag;
   end

   // Result select
   always_comb begin
      res_c_o = hilo_i;
      wr_c_o  = 1'b0;
      case (op_i)
         MD_MULT:  begin res_c_o = prod_s;                         wr_c_o = 1'b1; end
         MD_MULTU: begin res_c_o = prod_u;                         wr_c_o = 1'b1; end
         MD_DIV,
         MD_DIVU:  begin res_c_o = {r_res, q_res};                 wr_c_o = (b_i != '0); end
         MD_MADD:  begin res_c_o = hilo_t'(hilo_i + prod_s);       wr_c_o = 1'b1; end
         MD_MADDU: begin res_c_o = hilo_t'(hilo_i + prod_u);       wr_c_o = 1'b1; end
         default:  ;
      endcase
   end

endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: multi-cycle multiply/divide unit with HI/LO registers.
//   clk, rst_n : clock, async active-low reset
//   start      : qualifies MDop
//   MDop       : operation (mdu_pkg::md_op_e encoding)
//   A, B       : rs / rt operands
//   HI, LO     : architectural HI/LO registers
//   busy       : registered, high while an arithmetic op is in flight
// Optional: define MDU_MADD_EN to accept MADD/MADDU (accumulate into {HI,LO});
// otherwise those codes are no-ops.
module mdu_hilo
   import mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [3:0]      MDop,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   output logic [XLEN-1:0] HI,
   output logic [XLEN-1:0] LO,
   output logic            busy
);

   typedef enum logic {ST_IDLE, ST_RUN} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   hilo_t            hilo_q, hilo_d;
   hilo_t            pend_q, pend_d;
   logic             pend_wr_q, pend_wr_d;
   logic             busy_q, busy_d;

   md_op_e           op;
   hilo_t            arith_res;
   logic             arith_wr;
   logic             launch;

   assign op = md_op_e'(MDop);

   mdu_arith u_arith (
      .op_i    (op),
      .a_i     (A),
      .b_i     (B),
      .hilo_i  (hilo_q),
      .res_c_o (arith_res),
      .wr_c_o  (arith_wr)
   );

   // Next-state: accept ops only in IDLE; RUN counts down and commits on the last count
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hilo_d    = hilo_q;
      pend_d    = pend_q;
      pend_wr_d = pend_wr_q;
      launch    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               case (op)
                  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: launch = 1'b1;
`ifdef MDU_MADD_EN
                  MD_MADD, MD_MADDU:                  launch = 1'b1;
`endif
                  MD_MTHI: hilo_d.hi = A;
                  MD_MTLO: hilo_d.lo = A;
                  default: ;
               endcase
            end
            if (launch) begin
               pend_d    = arith_res;
               pend_wr_d = arith_wr;
               cnt_d     = is_div(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            if (cnt_q <= CNT_W'(1)) begin
               if (pend_wr_q) hilo_d = pend_q;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_RUN);
   end

   // State and architectural registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         hilo_q    <= '0;
         pend_q    <= '0;
         pend_wr_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hilo_q    <= hilo_d;
         pend_q    <= pend_d;
         pend_wr_q <= pend_wr_d;
         busy_q    <= busy_d;
      end
   end

   assign HI   = hilo_q.hi;
   assign LO   = hilo_q.lo;
   assign busy = busy_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// tb_mdu_hilo: self-checking bench for mdu_hilo with a cycle-indexed reference model.
module tb_mdu_hilo;

   localparam int unsigned MC = 5;
   localparam int unsigned DC = 10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  MDop;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        busy;

   always #5 clk = ~clk;

   mdu_hilo #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .MDop  (MDop),
      .A     (A),
      .B     (B),
      .HI    (HI),
      .LO    (LO),
      .busy  (busy)
   );

   int checks   = 0;
   int failures = 0;

   // Model: edge index of the last clock edge, edge at which the in-flight op commits
   longint unsigned edge_idx;
   longint unsigned done_idx;
   logic [31:0]     m_hi, m_lo;
   logic [63:0]     m_pend;
   logic            m_pwr;
   bit              chk_en = 1'b0;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic model_reset();
      edge_idx = 0;
      done_idx = 0;
      m_hi     = '0;
      m_lo     = '0;
      m_pend   = '0;
      m_pwr    = 1'b0;
   endtask

   // Applies the architectural rules for one clock edge given the current inputs
   task automatic model_edge();
      logic [63:0]     r;
      logic            w;
      logic            ok;
      longint unsigned n;
      longint          q, rr;
      edge_idx++;
      if (edge_idx == done_idx && m_pwr) {m_hi, m_lo} = m_pend;
      if (start && edge_idx > done_idx) begin
         ok = 1'b1; w = 1'b1; n = MC; r = '0;
         case (MDop)
            4'h1: r = 64'(longint'($signed(A)) * longint'($signed(B)));
            4'h2: r = {32'b0, A} * {32'b0, B};
            4'h3: begin
               n = DC;
               if (B == 0) w = 1'b0;
               else begin
                  q  = longint'($signed(A)) / longint'($signed(B));
                  rr = longint'($signed(A)) % longint'($signed(B));
                  r  = {rr[31:0], q[31:0]};
               end
            end
            4'h4: begin
               n = DC;
               if (B == 0) w = 1'b0;
               else r = {A % B, A / B};
            end
            4'h5: begin m_hi = A; ok = 1'b0; end
            4'h6: begin m_lo = A; ok = 1'b0; end
`ifdef MDU_MADD_EN
            4'h7: r = {m_hi, m_lo} + 64'(longint'($signed(A)) * longint'($signed(B)));
            4'h8: r = {m_hi, m_lo} + {32'b0, A} * {32'b0, B};
`endif
            default: ok = 1'b0;
         endcase
         if (ok) begin
            m_pend   = r;
            m_pwr    = w;
            done_idx = edge_idx + n;
         end
      end
   endtask

   task automatic step(input logic s, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      start = s; MDop = op; A = a; B = b;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Launch an op and count the busy cycles that follow (bounded)
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, output int lat);
      step(1'b1, op, a, b);
      lat = 0;
      while (busy && lat < 40) begin
         lat++;
         step(1'b0, 4'h0, 32'h0, 32'h0);
      end
   endtask

   function automatic logic [31:0] rnd_opnd();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return $urandom();
      endcase
   endfunction

   // Continuous comparison against the model on every falling edge
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("model_hi", HI, m_hi);
         chk("model_lo", LO, m_lo);
         chk("model_busy", busy, edge_idx < done_idx);
      end
   end

   initial begin
      int lat;
      rst_n = 1'b0; start = 1'b0; MDop = '0; A = '0; B = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk_en = 1'b1;

      // Reset state
      chk("rst_hi", HI, 32'h0);
      chk("rst_lo", LO, 32'h0);
      chk("rst_busy", busy, 1'b0);
      step(1'b0, 4'h0, 32'h0, 32'h0);

      // MULT / MULTU
      run_op(4'h1, 32'hFFFF_FFFE, 32'h3, lat);
      chk("mult_lat", lat, 5);
      chk("mult_hi", HI, 32'hFFFF_FFFF);
      chk("mult_lo", LO, 32'hFFFF_FFFA);
      run_op(4'h2, 32'hFFFF_FFFE, 32'h3, lat);
      chk("multu_lat", lat, 5);
      chk("multu_hi", HI, 32'h0000_0002);
      chk("multu_lo", LO, 32'hFFFF_FFFA);

      // DIV / DIVU by zero
      run_op(4'h3, 32'hFFFF_FFF9, 32'h2, lat);
      chk("div_lat", lat, 10);
      chk("div_hi", HI, 32'hFFFF_FFFF);
      chk("div_lo", LO, 32'hFFFF_FFFD);
      run_op(4'h4, 32'h7, 32'h0, lat);
      chk("divz_lat", lat, 10);
      chk("divz_hi", HI, 32'hFFFF_FFFF);
      chk("divz_lo", LO, 32'hFFFF_FFFD);

      // MTHI then MTLO back to back
      step(1'b1, 4'h5, 32'h1234_5678, 32'h0);
      chk("mthi_hi", HI, 32'h1234_5678);
      chk("mthi_busy", busy, 1'b0);
      step(1'b1, 4'h6, 32'h9ABC_DEF0, 32'h0);
      chk("mtlo_lo", LO, 32'h9ABC_DEF0);
      chk("mtlo_hi", HI, 32'h1234_5678);
      chk("mtlo_busy", busy, 1'b0);

      // Ops issued while busy, including the completion cycle, are dropped
      step(1'b1, 4'h3, 32'd100, 32'd7);
      for (int i = 0; i < 10; i++) step(1'b1, (i == 3) ? 4'h1 : 4'h5, 32'hDEAD_BEEF, 32'h3);
      chk("ign_busy", busy, 1'b0);
      chk("ign_hi", HI, 32'h2);
      chk("ign_lo", LO, 32'hE);
      step(1'b0, 4'h0, 32'h0, 32'h0);

      // Signed overflow divide
      run_op(4'h3, 32'h8000_0000, 32'hFFFF_FFFF, lat);
      chk("ovf_hi", HI, 32'h0);
      chk("ovf_lo", LO, 32'h8000_0000);

      // MADDU accumulate (or no-op when the feature is absent)
      step(1'b1, 4'h5, 32'h0, 32'h0);
      step(1'b1, 4'h6, 32'hFFFF_FFFF, 32'h0);
      run_op(4'h8, 32'h1, 32'h1, lat);
`ifdef MDU_MADD_EN
      chk("maddu_lat", lat, 5);
      chk("maddu_hi", HI, 32'h1);
      chk("maddu_lo", LO, 32'h0);
`else
      chk("maddu_lat", lat, 0);
      chk("maddu_hi", HI, 32'h0);
      chk("maddu_lo", LO, 32'hFFFF_FFFF);
`endif

      // Reset in the third busy cycle of a MULT aborts it
      step(1'b1, 4'h1, 32'h5, 32'h6);
      step(1'b0, 4'h0, 32'h0, 32'h0);
      step(1'b0, 4'h0, 32'h0, 32'h0);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("arst_busy", busy, 1'b0);
      chk("arst_hi", HI, 32'h0);
      chk("arst_lo", LO, 32'h0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (8) step(1'b0, 4'h0, 32'h0, 32'h0);
      chk("arst_nowr_hi", HI, 32'h0);
      chk("arst_nowr_lo", LO, 32'h0);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rnd_opnd(), rnd_opnd());
      end
      lat = 0;
      while (busy && lat < 40) begin
         lat++;
         step(1'b0, 4'h0, 32'h0, 32'h0);
      end
      chk("drain_busy", busy, 1'b0);
      step(1'b0, 4'h0, 32'h0, 32'h0);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
